inv_mix_columns_iter: RTL and testbench

Iterative AES InvMixColumns engine for the decryption datapath: accepts a 128-bit state, transforms one 32-bit column per clock through a shared GF(2^8) column unit, and presents the result under a valid/ready handshake. It sits between InvShiftRows/InvSubBytes and AddRoundKey in the inverse cipher round and complements the forward combinational MixColumns stage.

---
 rtl/aes_pkg.sv | 21 ++
 rtl/inv_mix_columns_iter_if.sv | 54 +++++
 rtl/inv_mix_column_word.sv | 45 ++++
 rtl/inv_mix_columns_iter.sv | 99 +++++++++
 tb/tb_inv_mix_columns_iter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and GF(2^8) helper.
// Used by the iterative InvMixColumns engine and its column unit.
package aes_pkg;

  localparam int STATE_W = 128;
  localparam int COL_W = 32;
  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/inv_mix_columns_iter_if.sv
// Handshake bundle for inv_mix_columns_iter.
// The fwd mode bit exists only when INV_MIX_DUAL_EN is defined.
interface inv_mix_columns_iter_if;
  import aes_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] out_data;
`ifdef INV_MIX_DUAL_EN
  logic               fwd;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    output fwd,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    input  fwd,
    output in_ready,
    output out_valid,
    output out_data
  );
`else
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
`endif

endinterface

// File: rtl/inv_mix_column_word.sv
// Combinational 32-bit AES column transform built from xtime chains.
// i_fwd=1 selects the forward MixColumns matrix, 0 the inverse one.
module inv_mix_column_word
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] i_col,
  input  logic             i_fwd,
  output logic [COL_W-1:0] o_col
);

  logic [7:0] w_a  [4];
  logic [7:0] w_x2 [4];
  logic [7:0] w_x4 [4];
  logic [7:0] w_x8 [4];

  for (genvar r = 0; r < 4; r++) begin : g_byte
    assign w_a[r]  = i_col[31-8*r -: 8];
    assign w_x2[r] = xtime(w_a[r]);
    assign w_x4[r] = xtime(w_x2[r]);
    assign w_x8[r] = xtime(w_x4[r]);
  end

  // Row r mixes bytes r, r+1, r+2, r+3 (mod 4) with one matrix row.
  for (genvar r = 0; r < 4; r++) begin : g_row
    localparam int R1 = (r + 1) % 4;
    localparam int R2 = (r + 2) % 4;
    localparam int R3 = (r + 3) % 4;

    logic [7:0] w_inv;
    logic [7:0] w_fw;

    assign w_inv = (w_x8[r]  ^ w_x4[r]  ^ w_x2[r])
                 ^ (w_x8[R1] ^ w_x2[R1] ^ w_a[R1])
                 ^ (w_x8[R2] ^ w_x4[R2] ^ w_a[R2])
                 ^ (w_x8[R3] ^ w_a[R3]);

    assign w_fw = w_x2[r]
                ^ (w_x2[R1] ^ w_a[R1])
                ^ w_a[R2]
                ^ w_a[R3];

    assign o_col[31-8*r -: 8] = i_fwd ? w_fw : w_inv;
  end

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative InvMixColumns: one column per clock through a shared unit.
// Define INV_MIX_DUAL_EN to add a latched fwd (MixColumns) mode.
module inv_mix_columns_iter
  import aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  inv_mix_columns_iter_if.slave bus
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_col;
  logic [STATE_W-1:0] r_data;
  logic [COL_W-1:0]   w_col_in;
  logic [COL_W-1:0]   w_col_out;
  logic               w_fwd;
  logic               w_accept;

  assign w_accept = (r_state == IDLE) && bus.in_valid;

`ifdef INV_MIX_DUAL_EN
  logic r_fwd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fwd <= 1'b0;
    end else if (w_accept) begin
      r_fwd <= bus.fwd;
    end
  end

  assign w_fwd = r_fwd;
`else
  assign w_fwd = 1'b0;
`endif

  always_comb begin
    w_col_in = r_data[127:96];
    unique case (r_col)
      2'd0: w_col_in = r_data[127:96];
      2'd1: w_col_in = r_data[95:64];
      2'd2: w_col_in = r_data[63:32];
      2'd3: w_col_in = r_data[31:0];
      default: w_col_in = r_data[127:96];
    endcase
  end

  inv_mix_column_word u_word (
    .i_col (w_col_in),
    .i_fwd (w_fwd),
    .o_col (w_col_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (bus.in_valid) w_state_nxt = BUSY;
      BUSY: if (r_col == 2'd3) w_state_nxt = DONE;
      DONE: if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Counter saturates at 3; it is cleared again on the next accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data <= '0;
      r_col  <= 2'd0;
    end else if (w_accept) begin
      r_data <= bus.in_data;
      r_col  <= 2'd0;
    end else if (r_state == BUSY) begin
      unique case (r_col)
        2'd0: r_data[127:96] <= w_col_out;
        2'd1: r_data[95:64]  <= w_col_out;
        2'd2: r_data[63:32]  <= w_col_out;
        2'd3: r_data[31:0]   <= w_col_out;
        default: r_data[127:96] <= w_col_out;
      endcase
      if (r_col != 2'd3) begin
        r_col <= r_col + 2'd1;
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_data  = r_data;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Directed and randomised checks for inv_mix_columns_iter.
// Expected values are constants or an independent GF(2^8) model.
module tb_inv_mix_columns_iter;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   cur_fwd = 1'b0;
  int   n_tot = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  inv_mix_columns_iter_if bus ();

  inv_mix_columns_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = t[7] ? ((t << 1) ^ 8'h1b) : (t << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(
    input logic [127:0] x,
    input bit           f
  );
    logic [127:0] y;
    logic [7:0]   a [4];
    logic [7:0]   k [4];
    logic [7:0]   acc;
    if (f) begin
      k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01;
    end else begin
      k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09;
    end
    y = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = x[127-32*c-8*r -: 8];
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(k[j], a[(r+j)%4]);
        y[127-32*c-8*r -: 8] = acc;
      end
    end
    return y;
  endfunction

  task automatic run_one(
    input  logic [127:0] x,
    output logic [127:0] y,
    output int           lat
  );
    int g;
    g = 0;
    bus.in_data  = x;
    bus.in_valid = 1'b1;
`ifdef INV_MIX_DUAL_EN
    bus.fwd = cur_fwd;
`endif
    while (!bus.in_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 50) chk("accept_timeout", 128'(g), 128'(0));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = ~x;
`ifdef INV_MIX_DUAL_EN
    bus.fwd = ~cur_fwd;
`endif
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    y = bus.out_data;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  localparam logic [127:0] FIPS_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] FIPS_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [127:0] y;
    logic [127:0] z;
    logic [127:0] x;
    logic [127:0] od;
    logic [127:0] xs [100];
    int           lat;
    int           sent;
    int           got;
    int           cyc;
    logic         acc;
    logic         ovl;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef INV_MIX_DUAL_EN
    bus.fwd = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_out_data", bus.out_data, 128'h0);
    rst_n = 1'b1;

    run_one(FIPS_IN, y, lat);
    chk("fips_data", y, FIPS_OUT);
    chk("fips_lat", 128'(lat), 128'(4));
    chk("fips_idle", 128'(bus.in_ready), 128'(1));

    run_one({4{32'hffffffff}}, y, lat);
    chk("fix_ff", y, {4{32'hffffffff}});
    run_one(128'h0, y, lat);
    chk("fix_00", y, 128'h0);
    run_one(128'h00000000_00000000_d5d5d7d6_00000000, y, lat);
    chk("fix_col2", y, 128'h00000000_00000000_d4d4d4d5_00000000);

    // Back-pressure hold
    bus.in_data  = FIPS_IN;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_lat", 128'(lat), 128'(4));
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = (i == 3);
      bus.in_data  = 128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef;
      @(posedge clk); #1;
      chk("bp_data", bus.out_data, FIPS_OUT);
      chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
      chk("bp_out_valid", 128'(bus.out_valid), 128'(1));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp_rel_ready", 128'(bus.in_ready), 128'(1));
    chk("bp_rel_valid", 128'(bus.out_valid), 128'(0));

    // Reset during BUSY
    bus.in_data  = {4{32'hffffffff}};
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("mrst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("mrst_out_data", bus.out_data, 128'h0);
    rst_n = 1'b1;
    run_one(FIPS_IN, y, lat);
    chk("mrst_data", y, FIPS_OUT);
    chk("mrst_lat", 128'(lat), 128'(4));

    // Streaming with random back-pressure
    for (int i = 0; i < 100; i++) begin
      xs[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 100 && cyc < 3000) begin
      bus.in_valid  = (sent < 100);
      bus.in_data   = xs[(sent < 100) ? sent : 99];
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      acc = bus.in_valid && bus.in_ready;
      ovl = bus.out_valid && bus.out_ready;
      od  = bus.out_data;
      @(posedge clk); #1;
      cyc++;
      if (acc) sent++;
      if (ovl) begin
        chk("b2b_data", od, model(xs[got], 1'b0));
        got++;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("b2b_got", 128'(got), 128'(100));
    chk("b2b_sent", 128'(sent), 128'(100));

`ifdef INV_MIX_DUAL_EN
    repeat (4) @(posedge clk);
    #1;
    x = {$urandom, $urandom, $urandom, $urandom};
    cur_fwd = 1'b1;
    run_one(x, y, lat);
    chk("dual_fwd", y, model(x, 1'b1));
    chk("dual_fwd_lat", 128'(lat), 128'(4));
    cur_fwd = 1'b0;
    run_one(y, z, lat);
    chk("dual_round", z, x);
    cur_fwd = 1'b1;
    run_one(FIPS_OUT, y, lat);
    chk("dual_fips", y, FIPS_IN);
    cur_fwd = 1'b0;
`else
    x = '0;
    z = '0;
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
